// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared types and frame layout for the TDC transmit scheduler
//
// Purpose: scheduler FSM state enum, default measurement width, UART frame
// field positions and a helper that packs one frame.
// Ports: none (package).

package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } sched_state_t;

  localparam int MEAS_W      = 40;
  localparam int FRAME_W     = 40;
  localparam int PAYLOAD_W   = 32;
  localparam int FR_CHAN_LSB = 36;
  localparam int FR_OVR      = 35;
  localparam int FR_SAT      = 34;

  // Frame: {chan[3:0], ovr, sat, 2'b00, payload[31:0]}
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [3:0]           chan,
    input logic                 ovr,
    input logic                 sat,
    input logic [PAYLOAD_W-1:0] payload
  );
    logic [FRAME_W-1:0] f;
    f                    = '0;
    f[FR_CHAN_LSB +: 4]  = chan;
    f[FR_OVR]            = ovr;
    f[FR_SAT]            = sat;
    f[PAYLOAD_W-1:0]     = payload;
    return f;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin winner selection
//
// Purpose: picks the first requesting channel searching from last+1 upward,
// wrapping modulo N_CH.
// Ports:
//   req  in  N_CH   request vector
//   last in  IDX_W  previously granted channel
//   gnt  out N_CH   one-hot grant (all zero when nothing requests)
//   idx  out IDX_W  encoded winner index
//   any  out 1      at least one request present

module rr_arbiter #(
  parameter int N_CH  = 4,
  parameter int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [N_CH-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin : pick
    int   c;
    logic found;
    gnt   = '0;
    idx   = '0;
    any   = |req;
    found = 1'b0;
    c     = 0;
    for (int k = 1; k <= N_CH; k++) begin
      c = (int'(last) + k) % N_CH;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = c[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/tdc_tx_scheduler.sv
// rtl/tdc_tx_scheduler.sv - shares one UART transmitter among N_CH TDC cores
//
// Purpose: arms idle enabled cores, keeps the latest measurement per channel
// in a one-deep buffer, and sends pending channels round-robin to uart_tx.
// Optional feature macro: TDC_SCHED_RATE_LIMIT_EN (frame rate limiter).
// Ports:
//   clk        in  1            system clock
//   rst        in  1            asynchronous active-high reset
//   ch_en      in  N_CH         per-channel enable
//   tdc_idle   in  N_CH         core i idle
//   meas       in  N_CH*MEAS_W  packed measurements, channel i at [MEAS_W*i +: MEAS_W]
//   meas_valid in  N_CH         measurement strobe per channel
//   arm        out N_CH         arm request per core
//   tx_data    out 40           frame to uart_tx
//   tx_valid   out 1            one-cycle start strobe to uart_tx
//   tx_busy    in  1            uart_tx busy
//   pending    out N_CH         buffer holds an unsent measurement
//   sched_busy out 1            FSM not in IDLE

module tdc_tx_scheduler
  import tdc_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int MEAS_W     = tdc_pkg::MEAS_W,
  parameter int CLK_FREQ   = 200_000_000,
  parameter int TX_RATE_HZ = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          ch_en,
  input  logic [N_CH-1:0]          tdc_idle,
  input  logic [N_CH*MEAS_W-1:0]   meas,
  input  logic [N_CH-1:0]          meas_valid,
  output logic [N_CH-1:0]          arm,
  output logic [39:0]              tx_data,
  output logic                     tx_valid,
  input  logic                     tx_busy,
  output logic [N_CH-1:0]          pending,
  output logic                     sched_busy
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  sched_state_t     state_q, state_d;
  logic [N_CH-1:0]  arm_q, pending_q, ovr_q;
  logic [MEAS_W-1:0] meas_buf [N_CH];
  logic [IDX_W-1:0] last_q;
  logic [FRAME_W-1:0] frame_q;

  logic [N_CH-1:0]  rr_req, rr_gnt, taken;
  logic [IDX_W-1:0] rr_idx;
  logic             rr_any;
  logic             rate_ok, grant;

  logic [MEAS_W-1:0]    win_meas;
  logic                 win_sat;
  logic [PAYLOAD_W-1:0] win_payload;

  // A disabled channel must never be granted, even in the cycle its
  // pending bit is being cleared.
  assign rr_req = pending_q & ch_en;

  rr_arbiter #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_rr (
    .req  (rr_req),
    .last (last_q),
    .gnt  (rr_gnt),
    .idx  (rr_idx),
    .any  (rr_any)
  );

  assign grant = (state_q == IDLE) && rr_any && rate_ok && !tx_busy;
  assign taken = grant ? rr_gnt : '0;

`ifdef TDC_SCHED_RATE_LIMIT_EN
  localparam int CLKS_PER_TX = CLK_FREQ / TX_RATE_HZ;
  localparam int CNT_W       = $clog2(CLKS_PER_TX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_TX);

  logic [CNT_W-1:0] rate_cnt_q;

  // Restarts as the frame enters START; START itself is counted as the first
  // cycle of the window so consecutive STARTs are exactly CLKS_PER_TX apart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate_cnt_q <= CNT_MAX;
    end else if (grant) begin
      rate_cnt_q <= CNT_W'(1);
    end else if (rate_cnt_q < CNT_MAX) begin
      rate_cnt_q <= rate_cnt_q + CNT_W'(1);
    end
  end

  assign rate_ok = (rate_cnt_q >= CNT_MAX);
`else
  assign rate_ok = 1'b1;
`endif

  // Frame contents come from the buffer as it stands at grant, so a capture
  // landing on the grant edge is queued again instead of overwriting the frame.
  assign win_meas    = meas_buf[rr_idx];
  assign win_sat     = |win_meas[MEAS_W-1:PAYLOAD_W];
  assign win_payload = win_sat ? '1 : win_meas[PAYLOAD_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_q     <= '0;
      pending_q <= '0;
      ovr_q     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        meas_buf[i] <= '0;
      end
    end else begin
      arm_q <= ch_en & tdc_idle;
      for (int i = 0; i < N_CH; i++) begin
        if (!ch_en[i]) begin
          pending_q[i] <= 1'b0;
          ovr_q[i]     <= 1'b0;
        end else if (meas_valid[i]) begin
          meas_buf[i]  <= meas[MEAS_W*i +: MEAS_W];
          pending_q[i] <= 1'b1;
          // Grant clears first, then the capture lands: overrun only if an
          // unsent value is being replaced.
          ovr_q[i]     <= !taken[i] && (ovr_q[i] || pending_q[i]);
        end else if (taken[i]) begin
          pending_q[i] <= 1'b0;
          ovr_q[i]     <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= IDX_W'(N_CH - 1);
      frame_q <= '0;
    end else if (grant) begin
      last_q  <= rr_idx;
      frame_q <= build_frame(4'(rr_idx), ovr_q[rr_idx], win_sat, win_payload);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (grant)    state_d = START;
      START:                   state_d = WAIT_ACK;
      WAIT_ACK:  if (tx_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_valid   = (state_q == START);
    sched_busy = (state_q != IDLE);
  end

  assign arm     = arm_q;
  assign pending = pending_q;
  assign tx_data = frame_q;

endmodule

// File: tb/tb_tdc_tx_scheduler.sv
// tb/tb_tdc_tx_scheduler.sv - self-checking bench for tdc_tx_scheduler

module tb_tdc_tx_scheduler;

  localparam int N_CH       = 4;
  localparam int MEAS_W     = 40;
  localparam int CLK_FREQ   = 1000;
  localparam int TX_RATE_HZ = 50;
  localparam int CPT        = CLK_FREQ / TX_RATE_HZ;
  localparam int UART_LEN   = 6;
`ifdef TDC_SCHED_RATE_LIMIT_EN
  localparam int EXP_GAP = CPT;
`else
  localparam int EXP_GAP = UART_LEN + 2;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_CH-1:0]        ch_en, tdc_idle, meas_valid, arm, pending;
  logic [N_CH*MEAS_W-1:0] meas;
  logic [39:0]            tx_data;
  logic                   tx_valid, sched_busy;
  logic                   tx_busy = 1'b0;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   busy_left = 0;
  logic uart_hold = 1'b0;
  int   mdl_last = N_CH - 1;

  logic [39:0] obs_q[$];
  int          obs_cyc[$];

  tdc_tx_scheduler #(
    .N_CH(N_CH), .MEAS_W(MEAS_W), .CLK_FREQ(CLK_FREQ), .TX_RATE_HZ(TX_RATE_HZ)
  ) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .tdc_idle(tdc_idle), .meas(meas),
    .meas_valid(meas_valid), .arm(arm), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_busy(tx_busy), .pending(pending), .sched_busy(sched_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // UART stand-in: busy for UART_LEN cycles starting with the START cycle.
  always @(negedge clk) begin
    if (rst) begin
      busy_left = 0;
      tx_busy   = 1'b0;
    end else if (uart_hold) begin
      tx_busy = 1'b1;
    end else if (tx_valid) begin
      busy_left = UART_LEN - 1;
      tx_busy   = 1'b1;
    end else if (busy_left > 0) begin
      busy_left--;
      tx_busy = 1'b1;
    end else begin
      tx_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst && tx_valid) begin
      obs_q.push_back(tx_data);
      obs_cyc.push_back(cyc);
    end
  end

  function automatic logic [39:0] mk_frame(input int ch, input bit o, input logic [39:0] v);
    bit          sat;
    logic [31:0] pay;
    sat = (v[39:32] != 8'h00);
    pay = sat ? 32'hFFFF_FFFF : v[31:0];
    return {4'(ch), o, sat, 2'b00, pay};
  endfunction

  function automatic int rr_pick(input bit [3:0] p, input int last);
    for (int k = 1; k <= N_CH; k++) begin
      if (p[(last + k) % N_CH]) return (last + k) % N_CH;
    end
    return -1;
  endfunction

  function automatic logic [39:0] rnd_meas();
    logic [7:0] hi;
    hi = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
    return {hi, 32'($urandom)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sched_busy || pending != '0) && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL %s drain_timeout sched_busy=%0b pending=%b required idle", tag, sched_busy, pending);
    end
    repeat (CPT + 2) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; ch_en = '0; tdc_idle = '0; meas = '0; meas_valid = '0;
    repeat (3) tick();
    checks++; if (arm !== 4'h0) begin failures++; $display("FAIL reset_arm got=%h exp=0", arm); end
    checks++; if (tx_data !== 40'h0) begin failures++; $display("FAIL reset_tx_data got=%h exp=0", tx_data); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (pending !== 4'h0) begin failures++; $display("FAIL reset_pending got=%h exp=0", pending); end
    checks++; if (sched_busy !== 1'b0) begin failures++; $display("FAIL reset_sched_busy got=%b exp=0", sched_busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_arming();
    logic [3:0] exp;
    for (int i = 0; i < 24; i++) begin
      ch_en    = 4'($urandom);
      tdc_idle = 4'($urandom);
      exp      = ch_en & tdc_idle;
      tick();
      checks++;
      if (arm !== exp) begin failures++; $display("FAIL arming[%0d] got=%b exp=%b", i, arm, exp); end
    end
    ch_en = 4'hF; tdc_idle = 4'hF;
    tick();
  endtask

  task automatic test_all_four();
    logic [39:0] v[4];
    obs_q.delete(); obs_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      v[i] = {8'h00, 32'($urandom)};
      meas[40*i +: 40] = v[i];
    end
    meas_valid = 4'hF; tick(); meas_valid = '0;
    drain("all_four");
    checks++;
    if (obs_q.size() != 4) begin failures++; $display("FAIL all_four_count got=%0d exp=4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== mk_frame(i, 1'b0, v[i])) begin
        failures++; $display("FAIL all_four_frame[%0d] got=%h exp=%h", i, obs_q[i], mk_frame(i, 1'b0, v[i]));
      end
      if (i > 0) begin
        checks++;
        if (obs_cyc[i] - obs_cyc[i-1] != EXP_GAP) begin
          failures++; $display("FAIL all_four_gap[%0d] got=%0d exp=%0d", i, obs_cyc[i] - obs_cyc[i-1], EXP_GAP);
        end
      end
    end
    mdl_last = 3;
  endtask

  task automatic test_single();
    meas[39:0] = 40'd1234; meas_valid = 4'h1;
    tick(); meas_valid = '0;
    checks++; if (pending[0] !== 1'b1) begin failures++; $display("FAIL single_pending_set got=%b exp=1", pending[0]); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", tx_valid); end
    tick();
    checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL single_tx_valid got=%b exp=1", tx_valid); end
    checks++; if (tx_data !== 40'h00_0000_04D2) begin failures++; $display("FAIL single_tx_data got=%h exp=00000004d2", tx_data); end
    checks++; if (pending[0] !== 1'b0) begin failures++; $display("FAIL single_pending_clr got=%b exp=0", pending[0]); end
    tick();
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL single_valid_one_cycle got=%b exp=0", tx_valid); end
    drain("single");
    mdl_last = 0;
  endtask

  task automatic test_overrun();
    obs_q.delete(); obs_cyc.delete();
    uart_hold = 1'b1; tick();
    meas[80 +: 40] = rnd_meas(); meas_valid = 4'h4; tick();
    checks++; if (pending[2] !== 1'b1) begin failures++; $display("FAIL ovr_pending got=%b exp=1", pending[2]); end
    meas[80 +: 40] = 40'd7; tick(); meas_valid = '0;
    uart_hold = 1'b0;
    drain("overrun");
    checks++;
    if (obs_q.size() != 1) begin failures++; $display("FAIL ovr_count got=%0d exp=1", obs_q.size()); end
    else begin
      checks++;
      if (obs_q[0] !== 40'h28_0000_0007) begin failures++; $display("FAIL ovr_frame got=%h exp=2800000007", obs_q[0]); end
    end
    mdl_last = 2;
  endtask

  task automatic test_saturate();
    obs_q.delete(); obs_cyc.delete();
    meas[40 +: 40] = 40'h01_0000_0000; meas_valid = 4'h2; tick(); meas_valid = '0;
    drain("saturate");
    checks++;
    if (obs_q.size() != 1) begin failures++; $display("FAIL sat_count got=%0d exp=1", obs_q.size()); end
    else begin
      checks++;
      if (obs_q[0] !== 40'h14_FFFF_FFFF) begin failures++; $display("FAIL sat_frame got=%h exp=14ffffffff", obs_q[0]); end
    end
    mdl_last = 1;
  endtask

  task automatic test_disable();
    obs_q.delete(); obs_cyc.delete();
    uart_hold = 1'b1; tick();
    meas[120 +: 40] = rnd_meas(); meas_valid = 4'h8; tick(); meas_valid = '0;
    checks++; if (pending[3] !== 1'b1) begin failures++; $display("FAIL dis_pending_set got=%b exp=1", pending[3]); end
    ch_en[3] = 1'b0; tick();
    checks++; if (pending[3] !== 1'b0) begin failures++; $display("FAIL dis_pending_clr got=%b exp=0", pending[3]); end
    checks++; if (arm[3] !== 1'b0) begin failures++; $display("FAIL dis_arm got=%b exp=0", arm[3]); end
    uart_hold = 1'b0;
    drain("disable");
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL dis_no_frame got=%0d exp=0", obs_q.size()); end
    ch_en = 4'hF; tick();
  endtask

  task automatic test_random();
    bit [3:0]    pend, ovr;
    logic [39:0] val[4];
    logic [39:0] exp_q[$];
    int          w;
    for (int r = 0; r < 12; r++) begin
      bit [3:0]    s1, s2;
      logic [39:0] nv;
      obs_q.delete(); obs_cyc.delete(); exp_q.delete();
      pend = '0; ovr = '0;
      s1 = 4'($urandom_range(1, 15));
      s2 = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        nv = rnd_meas(); meas[40*i +: 40] = nv;
        if (s1[i]) begin ovr[i] = ovr[i] | pend[i]; val[i] = nv; pend[i] = 1'b1; end
      end
      meas_valid = s1; tick();
      // second strobe cycle coincides with the first grant
      w = rr_pick(pend, mdl_last);
      exp_q.push_back(mk_frame(w, ovr[w], val[w]));
      pend[w] = 1'b0; ovr[w] = 1'b0; mdl_last = w;
      for (int i = 0; i < 4; i++) begin
        nv = rnd_meas(); meas[40*i +: 40] = nv;
        if (s2[i]) begin ovr[i] = ovr[i] | pend[i]; val[i] = nv; pend[i] = 1'b1; end
      end
      meas_valid = s2; tick(); meas_valid = '0;
      while (pend != '0) begin
        w = rr_pick(pend, mdl_last);
        exp_q.push_back(mk_frame(w, ovr[w], val[w]));
        pend[w] = 1'b0; ovr[w] = 1'b0; mdl_last = w;
      end
      drain("random");
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        failures++; $display("FAIL rand[%0d]_count got=%0d exp=%0d", r, obs_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
        checks++;
        if (obs_q[k] !== exp_q[k]) begin
          failures++; $display("FAIL rand[%0d]_frame[%0d] got=%h exp=%h", r, k, obs_q[k], exp_q[k]);
        end
        if (k > 0) begin
          checks++;
          if (obs_cyc[k] - obs_cyc[k-1] != EXP_GAP) begin
            failures++; $display("FAIL rand[%0d]_gap[%0d] got=%0d exp=%0d", r, k, obs_cyc[k] - obs_cyc[k-1], EXP_GAP);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int          n;
    logic [39:0] v0;
    meas[40 +: 40] = rnd_meas(); meas[80 +: 40] = rnd_meas();
    meas_valid = 4'h6; tick(); meas_valid = '0;
    n = 0;
    while (!tx_valid && n < 20) begin tick(); n++; end
    checks++; if (n >= 20) begin failures++; $display("FAIL rstmid_no_start got=0 exp=tx_valid"); end
    repeat (3) tick();
    checks++; if (sched_busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy got=%b exp=1", sched_busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (arm !== 4'h0) begin failures++; $display("FAIL rstmid_arm got=%h exp=0", arm); end
    checks++; if (tx_data !== 40'h0) begin failures++; $display("FAIL rstmid_tx_data got=%h exp=0", tx_data); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rstmid_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (pending !== 4'h0) begin failures++; $display("FAIL rstmid_pending got=%h exp=0", pending); end
    checks++; if (sched_busy !== 1'b0) begin failures++; $display("FAIL rstmid_sched_busy got=%b exp=0", sched_busy); end
    tick();
    rst = 1'b0;
    mdl_last = 3;
    obs_q.delete(); obs_cyc.delete();
    v0 = rnd_meas();
    meas[0 +: 40] = v0; meas[120 +: 40] = rnd_meas();
    meas_valid = 4'h9; tick(); meas_valid = '0;
    checks++; if (pending !== 4'h9) begin failures++; $display("FAIL rstmid_repend got=%h exp=9", pending); end
    tick();
    checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL rstmid_first_valid got=%b exp=1", tx_valid); end
    checks++;
    if (tx_data !== mk_frame(0, 1'b0, v0)) begin
      failures++; $display("FAIL rstmid_first_frame got=%h exp=%h", tx_data, mk_frame(0, 1'b0, v0));
    end
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_arming();
    test_all_four();
    test_single();
    test_overrun();
    test_saturate();
    test_disable();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
